// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared FSM encoding, timeout default and index-width helper
// Contents: state_e (arbiter FSM states), IDLE_TIMEOUT_DEFAULT, idx_width().
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD1 = 2'd2,
    ST_HOLD2 = 2'd3
  } state_e;

  localparam int IDLE_TIMEOUT_DEFAULT = 1024;

  // Width of a requester index; never below one bit so single-requester builds still elaborate.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin first-set selector
// Ports: valid  - candidate vector
//        ptr    - index searched first
//        idx    - first set index at or after ptr, wrapping
//        found  - any bit of valid set
module uart_tx_arbiter_rr_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int GW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [GW-1:0]      ptr,
  output logic [GW-1:0]      idx,
  output logic               found
);

  logic [GW-1:0] cand;

  // Walk from the farthest offset back to ptr so the nearest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = GW'((int'(ptr) + i) % NUM_REQ);
      if (valid[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - message-atomic round-robin arbiter feeding one uart_tx
// Ports: clk, rst_n (async, active-low)
//        req_valid/req_data/req_last/req_ready - per-requester byte streams
//        uart_ready, uart_out, uart_out_en      - byte interface to uart_tx
//        grant_id, busy, timeout_pulse          - status
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter  int NUM_REQ      = 4,
  parameter  int IDLE_TIMEOUT = IDLE_TIMEOUT_DEFAULT,
  localparam int GW           = idx_width(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic                   uart_ready,
  output logic [7:0]             uart_out,
  output logic                   uart_out_en,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   timeout_pulse
);

  localparam int CW = $clog2(IDLE_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]    out_q, out_d;
  logic          out_en_q, out_en_d;
  logic          tmo_q, tmo_d;
  logic          last_q, last_d;

  logic [GW-1:0] pick_idx;
  logic          pick_found;
  logic [GW-1:0] next_ptr;
  logic          xfer;

  uart_tx_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .valid (req_valid),
    .ptr   (rr_ptr_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

  assign next_ptr = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign xfer     = (state_q == ST_GRANT) && req_valid[grant_q] && uart_ready;

  always_comb begin
    req_ready = '0;
    if (state_q == ST_GRANT) req_ready[grant_q] = uart_ready;
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    idle_cnt_d = idle_cnt_q;
    out_d      = out_q;
    out_en_d   = 1'b0;
    tmo_d      = 1'b0;
    last_d     = last_q;
    case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (pick_found) begin
          grant_d = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A transfer always clears the idle count, so it takes priority over the timeout.
        if (xfer) begin
          out_d      = req_data[{grant_q, 3'b000} +: 8];
          out_en_d   = 1'b1;
          last_d     = req_last[grant_q];
          idle_cnt_d = '0;
          state_d    = ST_HOLD1;
        end else if (!req_valid[grant_q]) begin
          if (idle_cnt_q == CW'(IDLE_TIMEOUT - 1)) begin
            idle_cnt_d = '0;
            rr_ptr_d   = next_ptr;
            tmo_d      = 1'b1;
            state_d    = ST_IDLE;
          end else begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      // uart_tx lowers its ready one cycle late; skip that cycle rather than trust it.
      ST_HOLD1: state_d = ST_HOLD2;
      ST_HOLD2: begin
        if (last_q) begin
          rr_ptr_d = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          state_d  = ST_GRANT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= '0;
      idle_cnt_q <= '0;
      out_q      <= 8'h00;
      out_en_q   <= 1'b0;
      tmo_q      <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      idle_cnt_q <= idle_cnt_d;
      out_q      <= out_d;
      out_en_q   <= out_en_d;
      tmo_q      <= tmo_d;
      last_q     <= last_d;
    end
  end

  assign uart_out      = out_q;
  assign uart_out_en   = out_en_q;
  assign grant_id      = grant_q;
  assign busy          = (state_q != ST_IDLE);
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized and directed bench with message-level round-robin model
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_last, req_ready;
  logic [8*N-1:0] req_data;
  logic           uart_ready, uart_out_en, busy, timeout_pulse;
  logic [7:0]     uart_out;
  logic [1:0]     grant_id;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [7:0] mem [N][64];
  bit         lst [N][64];
  int         head [N];
  int         tail [N];

  logic [7:0] obs_b[$];
  int         obs_g[$];
  int         obs_c[$];
  int         pulse_c[$];
  logic [7:0] exp_b[$];
  int         exp_g[$];
  int         ready_viol;
  bit         rand_rdy;

  uart_tx_arbiter #(.NUM_REQ(N), .IDLE_TIMEOUT(TMO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .uart_ready    (uart_ready),
    .uart_out      (uart_out),
    .uart_out_en   (uart_out_en),
    .grant_id      (grant_id),
    .busy          (busy),
    .timeout_pulse (timeout_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (head[i] < tail[i]);
      req_data[8*i +: 8] = req_valid[i] ? mem[i][head[i]] : 8'h00;
      req_last[i]        = req_valid[i] ? lst[i][head[i]] : 1'b0;
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (head[i] < tail[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_msg(input int r, input int len, input logic [7:0] first, input bit rnd, input bit ends);
    for (int k = 0; k < len; k++) begin
      mem[r][tail[r]] = rnd ? 8'($urandom) : first + 8'(k);
      lst[r][tail[r]] = ends && (k == len - 1);
      tail[r]++;
    end
  endtask

  task automatic clear_obs();
    obs_b.delete(); obs_g.delete(); obs_c.delete(); pulse_c.delete();
    ready_viol = 0;
  endtask

  task automatic start();
    rst_n = 1'b0; uart_ready = 1'b0; rand_rdy = 1'b0;
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    drive();
    clear_obs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: observe at the falling edge, apply the handshake result after the rising edge.
  task automatic cycle();
    logic [N-1:0] xm;
    @(negedge clk);
    if (uart_out_en) begin
      obs_b.push_back(uart_out); obs_g.push_back(int'(grant_id)); obs_c.push_back(cyc);
    end
    if (timeout_pulse) pulse_c.push_back(cyc);
    if (req_ready != '0 && (!uart_ready || req_ready != (4'(1) << grant_id))) ready_viol++;
    xm = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (xm[i]) head[i]++;
    if (rand_rdy) uart_ready = ($urandom_range(0, 9) < 7);
    drive();
  endtask

  task automatic run(input string tag, input int budget);
    int n = 0;
    while ((pending() || busy) && n < budget) begin
      cycle();
      n++;
    end
    check({tag, "_drained"}, 32'(n < budget), 32'd1);
  endtask

  // Expected output: whole messages, owner chosen as first non-empty requester at/after the pointer.
  task automatic build_model();
    int h [N];
    int ptr, r;
    bit done, lb;
    exp_b.delete(); exp_g.delete();
    ptr = 0; done = 1'b0;
    for (int i = 0; i < N; i++) h[i] = head[i];
    while (!done) begin
      r = -1;
      for (int k = 0; k < N; k++)
        if (r < 0 && h[(ptr + k) % N] < tail[(ptr + k) % N]) r = (ptr + k) % N;
      if (r < 0) begin
        done = 1'b1;
      end else begin
        lb = 1'b0;
        while (!lb && h[r] < tail[r]) begin
          exp_b.push_back(mem[r][h[r]]); exp_g.push_back(r);
          lb = lst[r][h[r]];
          h[r]++;
        end
        ptr = (r + 1) % N;
      end
    end
  endtask

  task automatic compare(input string tag);
    check({tag, "_count"}, 32'(obs_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < obs_b.size() && i < exp_b.size(); i++) begin
      check($sformatf("%s_byte%0d", tag, i), 32'(obs_b[i]), 32'(exp_b[i]));
      check($sformatf("%s_gid%0d", tag, i), 32'(obs_g[i]), 32'(exp_g[i]));
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), 32'((obs_c[i] - obs_c[i-1]) >= 3), 32'd1);
    end
    check({tag, "_ready_viol"}, 32'(ready_viol), 32'd0);
  endtask

  initial begin
    int n, raise_cyc;
    rst_n = 1'b0; uart_ready = 1'b1; req_valid = '1; req_data = '0; req_last = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_en", 32'(uart_out_en), 32'd0);
    check("rst_out", 32'(uart_out), 32'd0);
    check("rst_grant", 32'(grant_id), 32'd0);
    check("rst_tmo", 32'(timeout_pulse), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);

    // Single two-byte message.
    start();
    add_msg(0, 2, 8'h41, 1'b0, 1'b1);
    uart_ready = 1'b1; drive(); build_model();
    run("single", 100);
    compare("single");
    check("single_b0", 32'(obs_b[0]), 32'h41);
    check("single_b1", 32'(obs_b[1]), 32'h42);
    check("single_spacing", 32'(obs_c[1] - obs_c[0]), 32'd3);
    check("single_busy_end", 32'(busy), 32'd0);

    // Contention between requesters 1 and 2.
    start();
    add_msg(1, 3, 8'h10, 1'b0, 1'b1);
    add_msg(2, 3, 8'h20, 1'b0, 1'b1);
    uart_ready = 1'b1; drive(); build_model();
    run("contend", 200);
    compare("contend");
    for (int i = 0; i < 6; i++) check($sformatf("contend_owner%0d", i), 32'(obs_g[i]), (i < 3) ? 32'd1 : 32'd2);

    // Fairness: single-byte messages from 0 and 3.
    start();
    for (int m = 0; m < 4; m++) begin
      add_msg(0, 1, 8'h00 + 8'(m), 1'b0, 1'b1);
      add_msg(3, 1, 8'h30 + 8'(m), 1'b0, 1'b1);
    end
    uart_ready = 1'b1; drive(); build_model();
    run("fair", 300);
    compare("fair");
    for (int i = 0; i < 8; i++) check($sformatf("fair_owner%0d", i), 32'(obs_g[i]), (i % 2 == 1) ? 32'd3 : 32'd0);

    // Backpressure: uart_ready low for 50 GRANT cycles.
    start();
    add_msg(0, 1, 8'h5A, 1'b0, 1'b1);
    uart_ready = 1'b0; drive();
    repeat (51) cycle();
    check("bp_no_strobe", 32'(obs_b.size()), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    uart_ready = 1'b1;
    #1;
    raise_cyc = cyc;
    check("bp_ready_rise", 32'(req_ready), 32'b0001);
    run("bp", 100);
    check("bp_count", 32'(obs_b.size()), 32'd1);
    check("bp_byte", 32'(obs_b[0]), 32'h5A);
    check("bp_latency", 32'(obs_c[0]), 32'(raise_cyc + 1));
    check("bp_ready_viol", 32'(ready_viol), 32'd0);

    // Idle timeout: requester 1 stalls mid-message.
    start();
    add_msg(1, 1, 8'h71, 1'b0, 1'b0);
    add_msg(2, 1, 8'h72, 1'b0, 1'b1);
    uart_ready = 1'b1; drive();
    run("tmo", 200);
    check("tmo_pulses", 32'(pulse_c.size()), 32'd1);
    check("tmo_when", 32'(pulse_c[0]), 32'(obs_c[0] + 2 + TMO));
    check("tmo_count", 32'(obs_b.size()), 32'd2);
    check("tmo_first_owner", 32'(obs_g[0]), 32'd1);
    check("tmo_next_owner", 32'(obs_g[1]), 32'd2);
    check("tmo_next_byte", 32'(obs_b[1]), 32'h72);

    // Reset while requester 3's first byte is in HOLD1.
    start();
    add_msg(1, 1, 8'h91, 1'b0, 1'b1);
    add_msg(3, 2, 8'hB0, 1'b0, 1'b1);
    uart_ready = 1'b1; drive();
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(uart_out_en && grant_id == 2'd3) && n < 200);
    check("rstmid_reach_hold1", 32'(n < 200), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstmid_out_en", 32'(uart_out_en), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_grant", 32'(grant_id), 32'd0);
    for (int i = 0; i < N; i++) begin head[i] = 0; tail[i] = 0; end
    add_msg(1, 1, 8'hA1, 1'b0, 1'b1);
    add_msg(3, 1, 8'hB3, 1'b0, 1'b1);
    drive();
    clear_obs();
    @(negedge clk);
    rst_n = 1'b1;
    run("rstmid", 100);
    check("rstmid_first_owner", 32'(obs_g[0]), 32'd1);
    check("rstmid_first_byte", 32'(obs_b[0]), 32'hA1);
    check("rstmid_second_owner", 32'(obs_g[1]), 32'd3);

    // Randomized traffic with random uart_ready.
    for (int round = 0; round < 6; round++) begin
      start();
      for (int r = 0; r < N; r++) begin
        int nm;
        nm = $urandom_range(0, 3);
        for (int m = 0; m < nm; m++) add_msg(r, $urandom_range(1, 4), 8'h00, 1'b1, 1'b1);
      end
      rand_rdy = 1'b1;
      uart_ready = $urandom_range(0, 1) == 1;
      drive(); build_model();
      run($sformatf("rand%0d", round), 3000);
      compare($sformatf("rand%0d", round));
      check($sformatf("rand%0d_no_tmo", round), 32'(pulse_c.size()), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
